// File: rtl/seg_scan_driver_pkg.sv
// Shared display definitions: segment encodings (gfedcba, active-high) and
// default scan timing, used by the scan driver and by the pattern producers.
package seg_scan_driver_pkg;

    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_DEAD_CYCLES = 1000;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    // Letters; several share a glyph with a hex digit.
    localparam logic [6:0] SEG_S = 7'h6D;
    localparam logic [6:0] SEG_T = 7'h78;
    localparam logic [6:0] SEG_G = 7'h3D;
    localparam logic [6:0] SEG_U = 7'h3E;
    localparam logic [6:0] SEG_P = 7'h73;
    localparam logic [6:0] SEG_L = 7'h38;
    localparam logic [6:0] SEG_N = 7'h54;
    localparam logic [6:0] SEG_R = 7'h50;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_E = 7'h79;

    // Digit k of a packed 8-digit pattern lives at bits [7k+6:7k].
    function automatic logic [6:0] digit_pattern(input logic [55:0] pat,
                                                 input logic [2:0]  idx);
        return pat[{3'b000, idx} * 6'd7 +: 7];
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between a pattern producer (master) and the scan driver (slave).
interface seg_scan_driver_if;
    import seg_scan_driver_pkg::*;

    // No handshake: the driver samples C_In/AN_In only in the cycle that
    // starts a frame and reports that sample with a one-cycle frame_tick.
    logic [55:0] C_In;
    logic [7:0]  AN_In;
    logic [7:0]  AN_Out;
    logic [6:0]  C_Out;
    logic        frame_tick;
    phase_e      phase;

    modport master (
        output C_In, AN_In,
        input  AN_Out, C_Out, frame_tick, phase
    );

    modport slave (
        input  C_In, AN_In,
        output AN_Out, C_Out, frame_tick, phase
    );

endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with per-slot blanking and
// a frame-wide snapshot of the pattern/enable inputs.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

    logic          run_q;
    logic [2:0]    digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        state_q, state_d;
    logic [55:0]   pat_q;
    logic [7:0]    en_q;
    logic          load;
    logic [7:0]    an_d;
    logic [6:0]    c_d;

    // Position of the next cycle; run_q low means the first edge after reset
    // lands on digit 0, count 0 and takes the snapshot.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        load    = 1'b0;
        if (!run_q) begin
            cnt_d   = '0;
            digit_d = '0;
            load    = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
            load    = (digit_q == 3'd7);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = PH_BLANK;
        if (int'(cnt_d) >= DEAD_CYCLES) state_d = PH_SHOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PH_BLANK;
        else     state_q <= state_d;
    end

    // Outputs are computed from the next position so the registered drive
    // lines up with the cycle they belong to. A load always falls in BLANK,
    // so the current snapshot is the right one whenever a digit is lit.
    always_comb begin
        an_d = 8'hFF;
        c_d  = 7'h7F;
        if (state_d == PH_SHOW && en_q[digit_d]) begin
            an_d = ~(8'd1 << digit_d);
            c_d  = ~digit_pattern(pat_q, digit_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q          <= 1'b0;
            cnt_q          <= '0;
            digit_q        <= '0;
            pat_q          <= '0;
            en_q           <= '0;
            bus.AN_Out     <= 8'hFF;
            bus.C_Out      <= 7'h7F;
            bus.frame_tick <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            if (load) begin
                pat_q <= bus.C_In;
                en_q  <= bus.AN_In;
            end
            bus.AN_Out     <= an_d;
            bus.C_Out      <= c_d;
            bus.frame_tick <= load;
        end
    end

    assign bus.phase = state_q;

    param_check: assert property (@(posedge clk)
        (DEAD_CYCLES >= 1) && (DEAD_CYCLES < REFRESH_DIV))
        else $error("seg_scan_driver: need 1 <= DEAD_CYCLES < REFRESH_DIV");

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed and model-checked bench for seg_scan_driver at REFRESH_DIV=8,
// DEAD_CYCLES=2 (8-cycle slots, 64-cycle frames).
module tb_seg_scan_driver;
    import seg_scan_driver_pkg::*;

    localparam int RD = 8;
    localparam int DC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cur_cycle = 0;

    seg_scan_driver_if bus();

    seg_scan_driver #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [55:0] c_in;
        logic [7:0]  an_in;
        int          cycle;
        logic [7:0]  exp_an;
        logic [6:0]  exp_c;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [55:0] put(input logic [55:0] base, input int k,
                                        input logic [6:0] p);
        logic [55:0] r;
        r = base;
        r[7*k +: 7] = p;
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic [55:0] c,
                                input logic [7:0] an, input int cyc,
                                input logic [7:0] ean, input logic [6:0] ec,
                                input logic et);
        vec_t v;
        v.name = n; v.c_in = c; v.an_in = an; v.cycle = cyc;
        v.exp_an = ean; v.exp_c = ec; v.exp_tick = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] ean,
                         input logic [6:0] ec, input logic et);
        tests++;
        if (bus.AN_Out !== ean || bus.C_Out !== ec || bus.frame_tick !== et) begin
            fails++;
            $display("FAIL %s cycle %0d: got AN=%b C=%b tick=%b, want AN=%b C=%b tick=%b",
                     name, cur_cycle, bus.AN_Out, bus.C_Out, bus.frame_tick, ean, ec, et);
        end
    endtask

    task automatic apply_reset(input logic [55:0] c, input logic [7:0] an);
        rst = 1'b1;
        bus.C_In = c;
        bus.AN_In = an;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 8'hFF, 7'h7F, 1'b0);
        rst = 1'b0;
        cur_cycle = -1;
    endtask

    task automatic advance_to(input int n);
        while (cur_cycle < n) begin
            @(posedge clk);
            @(negedge clk);
            cur_cycle++;
        end
    endtask

    logic [55:0] cfg_c;
    logic [7:0]  cfg_an;
    logic [55:0] c_b, c_c, c_d, c_e;
    logic [55:0] snap_c;
    logic [7:0]  snap_an;
    logic [7:0]  prev_an;
    logic [7:0]  e_an;
    logic [6:0]  e_c;
    logic        e_tick;
    bit          first;
    int          slot, dig;

    initial begin
        bus.C_In  = '0;
        bus.AN_In = '0;

        c_b = put(56'd0, 0, SEG_1);
        c_c = put(put(put(56'd0, 3, SEG_2), 4, SEG_4), 7, SEG_0);
        c_d = put(put(56'd0, 2, SEG_A), 1, SEG_3);

        vecs.push_back(mk("blank_c0",   56'd0, 8'hFF,  0, 8'hFF, 7'h7F, 1'b1));
        vecs.push_back(mk("blank_c1",   56'd0, 8'hFF,  1, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("zero_c2",    56'd0, 8'hFF,  2, 8'hFE, 7'h7F, 1'b0));
        vecs.push_back(mk("zero_c7",    56'd0, 8'hFF,  7, 8'hFE, 7'h7F, 1'b0));
        vecs.push_back(mk("d1_blank",   56'd0, 8'hFF,  8, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("d1_show",    56'd0, 8'hFF, 10, 8'hFD, 7'h7F, 1'b0));
        vecs.push_back(mk("one_c2",     c_b,   8'hFF,  2, 8'hFE, 7'h79, 1'b0));
        vecs.push_back(mk("one_c7",     c_b,   8'hFF,  7, 8'hFE, 7'h79, 1'b0));
        vecs.push_back(mk("d7_blank",   c_b,   8'hFF, 57, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("d7_c58",     c_b,   8'hFF, 58, 8'h7F, 7'h7F, 1'b0));
        vecs.push_back(mk("d7_c63",     c_b,   8'hFF, 63, 8'h7F, 7'h7F, 1'b0));
        vecs.push_back(mk("frame2_tick", c_b,  8'hFF, 64, 8'hFF, 7'h7F, 1'b1));
        vecs.push_back(mk("frame2_one", c_b,   8'hFF, 66, 8'hFE, 7'h79, 1'b0));
        vecs.push_back(mk("dis_c24",    c_c,   8'hF7, 24, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("dis_c26",    c_c,   8'hF7, 26, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("dis_c29",    c_c,   8'hF7, 29, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("dis_c31",    c_c,   8'hF7, 31, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("d4_c33",     c_c,   8'hF7, 33, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("d4_c34",     c_c,   8'hF7, 34, 8'hEF, 7'h19, 1'b0));
        vecs.push_back(mk("d7_zero",    c_c,   8'hF7, 58, 8'h7F, 7'h40, 1'b0));
        vecs.push_back(mk("only_d2_d1", c_d,   8'h04, 10, 8'hFF, 7'h7F, 1'b0));
        vecs.push_back(mk("only_d2_d2", c_d,   8'h04, 18, 8'hFB, 7'h08, 1'b0));

        first = 1'b1;
        foreach (vecs[i]) begin
            if (first || vecs[i].c_in !== cfg_c || vecs[i].an_in !== cfg_an ||
                vecs[i].cycle <= cur_cycle) begin
                apply_reset(vecs[i].c_in, vecs[i].an_in);
                cfg_c  = vecs[i].c_in;
                cfg_an = vecs[i].an_in;
                first  = 1'b0;
            end
            advance_to(vecs[i].cycle);
            check(vecs[i].name, vecs[i].exp_an, vecs[i].exp_c, vecs[i].exp_tick);
        end

        // Inputs change mid-frame; the display must keep the old snapshot.
        apply_reset(c_b, 8'hFF);
        advance_to(4);
        check("tear_one_c4", 8'hFE, 7'h79, 1'b0);
        advance_to(10);
        bus.C_In = put(put(56'd0, 0, SEG_2), 1, SEG_2);
        advance_to(12);
        check("tear_d1_old", 8'hFD, 7'h7F, 1'b0);
        advance_to(63);
        check("tear_c63", 8'h7F, 7'h7F, 1'b0);
        advance_to(64);
        check("tear_tick", 8'hFF, 7'h7F, 1'b1);
        advance_to(65);
        check("tear_c65", 8'hFF, 7'h7F, 1'b0);
        advance_to(66);
        check("tear_two", 8'hFE, 7'h24, 1'b0);
        advance_to(74);
        check("tear_d1_new", 8'hFD, 7'h24, 1'b0);

        // Asynchronous reset in the middle of digit 5's lit window.
        c_e = put(56'd0, 5, SEG_5);
        apply_reset(c_e, 8'hFF);
        advance_to(44);
        check("d5_show", 8'hDF, 7'h12, 1'b0);
        #1 rst = 1'b1;
        #1 check("async_rst", 8'hFF, 7'h7F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold", 8'hFF, 7'h7F, 1'b0);
        rst = 1'b0;
        cur_cycle = -1;
        advance_to(0);
        check("restart_tick", 8'hFF, 7'h7F, 1'b1);
        advance_to(2);
        check("restart_d0", 8'hFE, 7'h7F, 1'b0);
        advance_to(42);
        check("restart_d5", 8'hDF, 7'h12, 1'b0);

        // Random inputs over 100 frames against a cycle-position model.
        apply_reset(56'({$urandom(), $urandom()}), 8'($urandom_range(0, 255)));
        snap_c  = '0;
        snap_an = '0;
        prev_an = 8'hFF;
        for (int c = 0; c < 100 * 8 * RD; c++) begin
            @(posedge clk);
            @(negedge clk);
            cur_cycle = c;
            if (c % (8 * RD) == 0) begin
                snap_c  = bus.C_In;
                snap_an = bus.AN_In;
            end
            slot   = c % RD;
            dig    = (c / RD) % 8;
            e_tick = (c % (8 * RD) == 0);
            e_an   = 8'hFF;
            e_c    = 7'h7F;
            if (slot >= DC && snap_an[dig]) begin
                e_an = ~(8'd1 << dig);
                e_c  = ~snap_c[7*dig +: 7];
            end
            check("rand_model", e_an, e_c, e_tick);

            tests++;
            if ($countones(~bus.AN_Out) > 1) begin
                fails++;
                $display("FAIL one_low cycle %0d: got AN=%b, want at most one low bit",
                         c, bus.AN_Out);
            end
            tests++;
            if (prev_an != 8'hFF && bus.AN_Out != 8'hFF && bus.AN_Out != prev_an) begin
                fails++;
                $display("FAIL no_blank_gap cycle %0d: got AN=%b after AN=%b, want a blank cycle between",
                         c, bus.AN_Out, prev_an);
            end
            prev_an = bus.AN_Out;

            if ($urandom_range(0, 15) == 0) begin
                bus.C_In  = 56'({$urandom(), $urandom()});
                bus.AN_In = 8'($urandom_range(0, 255));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
